// File: rtl/negarb_pkg.sv
// negarb_pkg: shared types and constants for the negate/increment arbiter.
//   state_t          - response slot state (EMPTY / FULL)
//   NEGARB_WIDTH     - default operand width
//   STATS_W          - width of the optional per-requester grant counters
//   signed_min/max() - most-negative / most-positive two's complement value
//                      for a given width, returned in a LIMIT_W-bit container
package negarb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int NEGARB_WIDTH = 32;
    localparam int STATS_W      = 16;
    localparam int LIMIT_W      = 64;

    function automatic logic [LIMIT_W-1:0] signed_min(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

    function automatic logic [LIMIT_W-1:0] signed_max(input int unsigned w);
        return signed_min(w) - 64'd1;
    endfunction

endpackage

// File: rtl/inc_chain.sv
// inc_chain: combinational half-adder ripple, {cout, sum} = a + cin.
// Ports:
//   a    in  WIDTH  operand
//   cin  in  1      carry in
//   sum  out WIDTH  result
//   cout out 1      carry out of the top bit
module inc_chain #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ha
        assign sum[i]     = a[i] ^ carry[i];
        assign carry[i+1] = a[i] & carry[i];
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/negate_arbiter.sv
// negate_arbiter: round-robin arbiter sharing one increment/negate carry chain
// between NREQ requesters, with a single registered response slot.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req_valid   in  NREQ        per-requester request valid
//   req_ready   out NREQ        one-hot grant (zero when nothing granted)
//   req_neg     in  NREQ        1 = negate (~x+1), 0 = increment (x+1)
//   req_data    in  NREQ*WIDTH  operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid   out 1           response slot full
//   rsp_ready   in  1           consumer accepts response
//   rsp_data    out WIDTH       result
//   rsp_id      out IDW         requester that produced rsp_data
//   rsp_cout    out 1           carry out of the chain
//   rsp_ovf     out 1           signed overflow
//   grant_cnt   out NREQ*16     saturating grant counters (NEG_STATS_EN only)
// Build option: define NEG_STATS_EN to add the grant counters and grant_cnt.
module negate_arbiter
    import negarb_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = NEGARB_WIDTH,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_neg,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_cout,
    output logic                  rsp_ovf
`ifdef NEG_STATS_EN
   ,output logic [NREQ*STATS_W-1:0] grant_cnt
`endif
);

    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(signed_min(WIDTH));
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(signed_max(WIDTH));

    state_t           state_q, state_d;
    logic             accept;
    logic             gnt_any;
    logic [IDW-1:0]   gnt_idx;
    logic [IDW-1:0]   rr_ptr;

    logic [WIDTH-1:0] x_sel;
    logic             neg_sel;
    logic [WIDTH-1:0] a_op;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    assign rsp_valid = (state_q == FULL);
    // The slot can take a new result when empty or when it drains this cycle.
    assign accept    = (state_q == EMPTY) | (rsp_valid & rsp_ready);

    // Round-robin scan starting at rr_ptr; pos is one bit wider so the
    // wrap can be done with a single conditional subtract.
    always_comb begin
        logic [IDW:0] pos;
        gnt_any = 1'b0;
        gnt_idx = '0;
        pos     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (pos >= (IDW+1)'(NREQ)) begin
                pos = pos - (IDW+1)'(NREQ);
            end
            if (!gnt_any && req_valid[pos[IDW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = pos[IDW-1:0];
            end
        end
        if (!accept || !rst_n) begin
            gnt_any = 1'b0;
            gnt_idx = '0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   state_d = gnt_any ? FULL : EMPTY;
            FULL:    begin
                if (rsp_ready) begin
                    state_d = gnt_any ? FULL : EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Output logic: one-hot grant
    always_comb begin
        req_ready = '0;
        if (gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Operand select for the granted requester
    always_comb begin
        x_sel   = '0;
        neg_sel = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                x_sel   = req_data[i*WIDTH +: WIDTH];
                neg_sel = req_neg[i];
            end
        end
    end

    assign a_op = neg_sel ? ~x_sel : x_sel;

    inc_chain #(
        .WIDTH (WIDTH)
    ) u_chain (
        .a    (a_op),
        .cin  (1'b1),
        .sum  (sum),
        .cout (cout)
    );

    // Only the two operands that cross the sign boundary overflow.
    assign ovf = neg_sel ? (x_sel == MIN_V) : (x_sel == MAX_V);

    // Response slot and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_id   <= '0;
            rsp_cout <= 1'b0;
            rsp_ovf  <= 1'b0;
            rr_ptr   <= '0;
        end else if (gnt_any) begin
            rsp_data <= sum;
            rsp_id   <= gnt_idx;
            rsp_cout <= cout;
            rsp_ovf  <= ovf;
            rr_ptr   <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

`ifdef NEG_STATS_EN
    logic [STATS_W-1:0] cnt_q [NREQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (gnt_any && gnt_idx == IDW'(i) && cnt_q[i] != '1) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            grant_cnt[i*STATS_W +: STATS_W] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_negate_arbiter.sv
// tb_negate_arbiter: directed self-checking bench for negate_arbiter
// (NREQ=4, WIDTH=32). Counter checks are compiled in with NEG_STATS_EN.
module tb_negate_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_neg;
    logic [NREQ*WIDTH-1:0] req_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_cout;
    logic                  rsp_ovf;
`ifdef NEG_STATS_EN
    logic [NREQ*16-1:0]    grant_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    negate_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_neg   (req_neg),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf)
`ifdef NEG_STATS_EN
       ,.grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic neg, input logic [31:0] d);
        req_neg[i]           = neg;
        req_data[i*32 +: 32] = d;
    endtask

    // One request from requester i; assumes the slot can accept this cycle.
    task automatic single_op(input string tag, input int i, input logic neg,
                             input logic [31:0] d, input logic [31:0] exp_d,
                             input logic exp_c, input logic exp_o);
        req_valid = '0;
        req_valid[i] = 1'b1;
        set_op(i, neg, d);
        rsp_ready = 1'b1;
        #1;
        check({tag, "_rdy"}, req_ready, 64'(4'b0001 << i));
        step();
        req_valid = '0;
        check({tag, "_vld"},  rsp_valid, 1);
        check({tag, "_data"}, rsp_data, exp_d);
        check({tag, "_id"},   rsp_id, i);
        check({tag, "_cout"}, rsp_cout, exp_c);
        check({tag, "_ovf"},  rsp_ovf, exp_o);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_neg   = '0;
        req_data  = '0;
        rsp_ready = 1'b0;

        // Reset state, with requests pending to show the grant is gated.
        #3;
        check("rst_vld",  rsp_valid, 0);
        check("rst_data", rsp_data, 0);
        check("rst_id",   rsp_id, 0);
        check("rst_cout", rsp_cout, 0);
        check("rst_ovf",  rsp_ovf, 0);
        check("rst_rdy",  req_ready, 0);
`ifdef NEG_STATS_EN
        check("rst_cnt",  grant_cnt, 0);
`endif
        step();
        req_valid = '0;
        step();
        rst_n = 1'b1;
        step();

        // Single request: requester 2 negates 5 (rr_ptr -> 3).
        single_op("neg5", 2, 1'b1, 32'h0000_0005, 32'hFFFF_FFFB, 1'b0, 1'b0);

        // Boundary operands on requester 3 (rr_ptr -> 0).
        single_op("neg_min", 3, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        single_op("neg_0",   3, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
        single_op("inc_max", 3, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1);
        single_op("inc_ff",  3, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        single_op("inc_10",  3, 1'b0, 32'h0000_0010, 32'h0000_0011, 1'b0, 1'b0);

        // Round-robin: all four valid, six back-to-back grants 0,1,2,3,0,1.
        for (int i = 0; i < NREQ; i++) begin
            set_op(i, 1'b0, 32'(i * 32'h100));
        end
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rr_rdy", req_ready, 64'(4'b0001 << (k % 4)));
            step();
            check("rr_vld",  rsp_valid, 1);
            check("rr_id",   rsp_id, k % 4);
            check("rr_data", rsp_data, (k % 4) * 32'h100 + 1);
        end
        req_valid = '0;
        step();
        check("drain1_vld", rsp_valid, 0);

        // Move rr_ptr to 1 so requester 1 wins ahead of 3.
        single_op("ptr_fix", 0, 1'b0, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
        step();
        check("drain2_vld", rsp_valid, 0);

        // Backpressure: requesters 1 and 3 valid, consumer stalled 5 cycles.
        rsp_ready = 1'b0;
        set_op(1, 1'b0, 32'h0000_0041);
        set_op(3, 1'b1, 32'h0000_0001);
        req_valid = 4'b1010;
        #1;
        check("bp_rdy0", req_ready, 4'b0010);
        step();
        check("bp_vld0",  rsp_valid, 1);
        check("bp_id0",   rsp_id, 1);
        check("bp_data0", rsp_data, 32'h0000_0042);
        for (int c = 1; c < 5; c++) begin
            check("bp_hold_rdy", req_ready, 0);
            step();
            check("bp_hold_vld",  rsp_valid, 1);
            check("bp_hold_id",   rsp_id, 1);
            check("bp_hold_data", rsp_data, 32'h0000_0042);
            check("bp_hold_cout", rsp_cout, 0);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_rel_rdy", req_ready, 4'b1000);
        step();
        check("bp_rel_vld",  rsp_valid, 1);
        check("bp_rel_id",   rsp_id, 3);
        check("bp_rel_data", rsp_data, 32'hFFFF_FFFF);
        check("bp_next_rdy", req_ready, 4'b0010);
        step();
        check("bp_next_vld",  rsp_valid, 1);
        check("bp_next_id",   rsp_id, 1);
        check("bp_next_data", rsp_data, 32'h0000_0042);

        // Async reset mid-cycle while FULL.
        rsp_ready = 1'b0;
        req_valid = '0;
        #3;
        rst_n = 1'b0;
        req_valid = 4'b1001;
        #1;
        check("arst_vld",  rsp_valid, 0);
        check("arst_data", rsp_data, 0);
        check("arst_id",   rsp_id, 0);
        check("arst_rdy",  req_ready, 0);
        step();
        step();
        set_op(0, 1'b0, 32'h0000_0020);
        set_op(3, 1'b0, 32'h0000_0030);
        rsp_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        check("post_rdy0", req_ready, 4'b0001);
        step();
        check("post_id0",   rsp_id, 0);
        check("post_data0", rsp_data, 32'h0000_0021);
        check("post_rdy3",  req_ready, 4'b1000);
        step();
        check("post_id3",   rsp_id, 3);
        check("post_data3", rsp_data, 32'h0000_0031);
        req_valid = '0;

`ifdef NEG_STATS_EN
        // 70000 grants to requester 1 saturate its counter at 0xFFFF.
        req_valid = 4'b0010;
        repeat (70000) step();
        req_valid = '0;
        step();
        check("cnt0", grant_cnt[0*16 +: 16], 16'd1);
        check("cnt1", grant_cnt[1*16 +: 16], 16'hFFFF);
        check("cnt2", grant_cnt[2*16 +: 16], 16'd0);
        check("cnt3", grant_cnt[3*16 +: 16], 16'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
